// File: rtl/pow_5_res_fifo.sv
// Result FIFO behind the pow_5 unit: first-word fall-through, no backpressure to upstream.
// Drops are reported through a sticky overflow flag that only reset clears.
module pow_5_res_fifo #(
    parameter int w     = 8,
    parameter int depth = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clk_en,
    input  logic                     in_vld,
    input  logic [w-1:0]             in_data,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [w-1:0]             out_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(depth):0]   count,
    output logic                     overflow
);

    localparam int AW    = $clog2(depth);
    localparam int CNT_W = AW + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(depth);
    localparam logic [AW-1:0]    PTR_ONE   = AW'(1);

    logic [w-1:0]     r_mem [depth];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic [CNT_W-1:0] w_count_nxt;

    // Status comes from the registered count only, so out_rdy/in_vld never reach an output.
    assign w_full  = (r_count == CNT_DEPTH);
    assign w_empty = (r_count == CNT_ZERO);

    assign w_pop  = clk_en & ~w_empty & out_rdy;
    assign w_push = clk_en & in_vld & (~w_full | w_pop);
    assign w_drop = clk_en & in_vld & w_full & ~w_pop;

    always_comb begin
        // NOTE: default first so every path assigns w_count_nxt and no latch is inferred.
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // NOTE: storage has no reset; stale words are never visible because empty gates out_vld.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= w_count_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign out_vld  = ~w_empty;
    assign out_data = r_mem[r_rd_ptr];
    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_pow_5_res_fifo.sv
// Directed bench for pow_5_res_fifo (w=8, depth=4) with hand-computed expectations.
module tb_pow_5_res_fifo;

    logic       clk;
    logic       rst_n;
    logic       clk_en;
    logic       in_vld;
    logic [7:0] in_data;
    logic       out_vld;
    logic       out_rdy;
    logic [7:0] out_data;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] r_model [$];
    logic [7:0] seq_a [4] = '{8'd0, 8'd1, 8'd32, 8'd243};

    pow_5_res_fifo #(.w(8), .depth(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_en   (clk_en),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        step();
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] pow5(input int n);
        int p;
        p = n * n * n * n * n;
        return p[7:0];
    endfunction

    initial begin
        rst_n   = 1'b0;
        clk_en  = 1'b0;
        in_vld  = 1'b0;
        in_data = '0;
        out_rdy = 1'b0;
        #2;
        check("rst_out_vld", out_vld, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        step();
        rst_n  = 1'b1;
        clk_en = 1'b1;

        // Fill with 0,1,32,243 while the consumer stalls.
        for (int i = 0; i < 4; i++) begin
            in_vld  = 1'b1;
            in_data = seq_a[i];
            step();
            check($sformatf("fill_count_%0d", i), count, i + 1);
            check($sformatf("fill_vld_%0d", i), out_vld, 1);
        end
        check("fill_full", full, 1);
        check("fill_head", out_data, 0);

        // Push into a full FIFO with no pop: dropped, overflow sticks.
        in_data = 8'd53;
        step();
        check("drop_count", count, 4);
        check("drop_overflow", overflow, 1);
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drop_drain_%0d", i), out_data, seq_a[i]);
            step();
        end
        check("drop_empty", empty, 1);
        check("drop_vld", out_vld, 0);
        check("drop_overflow_sticky", overflow, 1);
        out_rdy = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("async_clr_overflow", overflow, 0);
        step();
        rst_n = 1'b1;

        // Full with simultaneous push and pop: both accepted, no overflow.
        in_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = seq_a[i];
            step();
        end
        in_data = 8'd53;
        out_rdy = 1'b1;
        check("pp_head_before", out_data, 0);
        step();
        check("pp_count", count, 4);
        check("pp_overflow", overflow, 0);
        check("pp_full", full, 1);
        in_vld = 1'b0;
        check("pp_drain_0", out_data, 1);
        step();
        check("pp_drain_1", out_data, 32);
        step();
        check("pp_drain_2", out_data, 243);
        step();
        check("pp_drain_3", out_data, 53);
        step();
        check("pp_empty", empty, 1);

        // Empty with in_vld and out_rdy: push only, no same-cycle bypass.
        in_vld  = 1'b1;
        in_data = 8'd7;
        #1;
        check("nobypass_vld", out_vld, 0);
        step();
        check("first_vld", out_vld, 1);
        check("first_count", count, 1);
        out_rdy = 1'b0;
        in_data = 8'd9;
        step();
        check("two_count", count, 2);

        // Clock enable low: everything holds, in_vld ignored.
        clk_en  = 1'b0;
        in_vld  = 1'b1;
        in_data = 8'd99;
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold_count_%0d", i), count, 2);
            check($sformatf("hold_data_%0d", i), out_data, 7);
            check($sformatf("hold_ovf_%0d", i), overflow, 0);
        end
        clk_en = 1'b1;
        in_vld = 1'b0;
        check("hold_drain_0", out_data, 7);
        step();
        check("hold_drain_1", out_data, 9);
        step();
        check("hold_empty", empty, 1);

        // Eight writes with pops on odd cycles; pointers wrap around.
        r_model.delete();
        for (int i = 0; i < 8; i++) begin
            in_vld  = 1'b1;
            in_data = pow5(i + 4);
            out_rdy = (i % 2 == 1);
            if (out_rdy && r_model.size() > 0) begin
                check($sformatf("wrap_out_%0d", i), out_data, r_model[0]);
                void'(r_model.pop_front());
            end
            r_model.push_back(in_data);
            step();
            check($sformatf("wrap_count_%0d", i), count, r_model.size());
        end
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("wrap_drain_%0d", i), out_data, r_model[0]);
            void'(r_model.pop_front());
            step();
        end
        check("mid_count", count, 2);

        // Reset between edges discards entries immediately.
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_vld", out_vld, 0);
        check("midrst_count", count, 0);
        check("midrst_empty", empty, 1);
        check("midrst_full", full, 0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_empty", empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
